mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle multiply/divide responder for the pipeline's E-stage Start/Busy handshake.
- The E stage issues an operation with Start, operands and Op. This block owns the HI/LO registers, holds Busy for a fixed latency, then commits the result.
- The hazard unit stalls any HI/LO reader or new MDU instruction while Start or Busy is high.
- Out returns HI or LO for mfhi/mflo, selected by Sel.

Parameters:
- MUL_CYCLES, 5, Busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, Busy cycles for div/divu (must be ≥1).
- CNT_W, 4, counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- Start  in  1  single-cycle issue strobe from the E stage.
- Op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- Sel  in  1  0 selects LO, 1 selects HI on Out.
- Out  out  32  combinational: Sel ? HI : LO.
- Busy  out  1  registered; high while an operation is in flight.

Behaviour:
- Reset (clk edge with rst=1):
  - HI=0, LO=0, cnt=0, pending result=0.
  - Busy=0 and Out=0 after the edge.
  - Reset wins over Start on the same edge.
  - Reset mid-operation aborts it; no commit occurs.
- States: IDLE (cnt==0) and RUN (cnt!=0). Busy = (cnt!=0), driven directly from the register.
- Issue:
  - Start is sampled only in IDLE. Start while in RUN is ignored.
  - The hazard unit guarantees this cannot happen; the bench checks that HI/LO and cnt are unaffected.
- mult/multu, Start at edge t:
  - Compute the 64-bit product (signed or unsigned) from A and B sampled at t.
  - Store the product in the pending registers; cnt <= MUL_CYCLES.
- div/divu, Start at edge t:
  - pending LO = quotient, pending HI = remainder; cnt <= DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
  - Divide by zero: the op still runs DIV_CYCLES with Busy high, but HI/LO stay unchanged at commit.
- mthi/mtlo, Start at edge t:
  - HI (or LO) <= A at edge t. cnt stays 0, so Busy never rises.
- Op 6/7 with Start: no state change.
- RUN:
  - Each edge, cnt decrements.
  - On the edge where cnt==1: HI/LO <= pending (unless div-by-zero) and cnt <= 0.
  - Result: Busy is high for exactly N cycles after the issue edge; new HI/LO are visible on Out in the first cycle with Busy=0.
- While Busy, Out shows the old HI/LO.
- Back-to-back issue: Start is accepted in the same cycle Busy falls, because cnt is already 0.
- Operands are latched at issue. A and B changes during RUN have no effect.
- Arithmetic:
  - Signed ops use two's complement on the full 32-bit operands.
  - Unsigned ops zero-extend.
  - The product is 64 bits: HI=[63:32], LO=[31:0].

Test Plan:
- Reset then Sel=0/1 → Out=0, Busy=0. Assert rst during a div at cycle 3 → HI=LO=0, Busy=0 on the next cycle, no commit.
- mult A=0xFFFFFFFF, B=2 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1.
- mthi A=0x1234, then mtlo A=0x5678 on consecutive cycles → Busy stays 0; HI=0x1234 and LO=0x5678, each visible the cycle after its Start.
- Preload HI=0xAA, LO=0xBB, then div with B=0 → Busy 10 cycles, then HI=0xAA, LO=0xBB. Then div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start a mult, then pulse Start with Op=mtlo during RUN → ignored (LO equals the product after commit). Issue a new mult in the first cycle Busy=0 → accepted, Busy rises on the next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Purpose : iterative-latency multiply/divide unit owning HI/LO for the E-stage Start/Busy handshake.
// Latency : mult/multu hold Busy MUL_CYCLES cycles, div/divu DIV_CYCLES; mthi/mtlo write HI/LO at the issue edge.
// Backpr. : none internal; Busy tells the hazard unit to stall, and Start is ignored while an op is in flight.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Start, Op       issue strobe and operation (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op)
//   A, B            forwarded rs/rt operands, sampled only on the issue edge
//   Sel, Out        Out = Sel ? HI : LO (combinational)
//   Busy            registered, high while a mult/div is in flight
module mdu_iter #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [31:0]       A,
   input  logic [31:0]       B,
   input  logic              Sel,
   output logic [31:0]       Out,
   output logic              Busy
);

   typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // architectural and in-flight state
   logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
   logic             pend_dz_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   logic [31:0]      hi_nxt, lo_nxt, pend_hi_nxt, pend_lo_nxt;
   logic             pend_dz_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   state_t           state;

   assign state = (cnt_q != '0) ? RUN : IDLE;

   // ------------------------------------------------------------------
   // Datapath: one multiplier and one unsigned divider shared by the
   // signed and unsigned variants.
   // ------------------------------------------------------------------
   logic        is_signed;
   logic [63:0] mul_a, mul_b, product;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, div_den, uq, ur, quo, rem;

   assign is_signed = (Op == OP_MULT) || (Op == OP_DIV);

   // Sign/zero-extend to 64 bits; the low 64 bits of the product are then
   // correct for both signed and unsigned operands.
   assign mul_a   = {{32{is_signed & A[31]}}, A};
   assign mul_b   = {{32{is_signed & B[31]}}, B};
   assign product = mul_a * mul_b;

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // follows the dividend. |0x80000000| is 2^31 as an unsigned value, so
   // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
   assign neg_a   = is_signed & A[31];
   assign neg_b   = is_signed & B[31];
   assign mag_a   = neg_a ? (~A + 32'd1) : A;
   assign mag_b   = neg_b ? (~B + 32'd1) : B;
   // A zero divisor is replaced so the divider never sees it; the result is
   // discarded at commit anyway.
   assign div_den = (B == 32'd0) ? 32'd1 : mag_b;
   assign uq      = mag_a / div_den;
   assign ur      = mag_a % div_den;
   assign quo     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
   assign rem     = neg_a ? (~ur + 32'd1) : ur;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      hi_nxt      = hi_q;
      lo_nxt      = lo_q;
      pend_hi_nxt = pend_hi_q;
      pend_lo_nxt = pend_lo_q;
      pend_dz_nxt = pend_dz_q;
      cnt_nxt     = cnt_q;

      case (state)
         IDLE: begin
            if (Start) begin
               case (Op)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_nxt = product[63:32];
                     pend_lo_nxt = product[31:0];
                     pend_dz_nxt = 1'b0;
                     cnt_nxt     = CNT_W'(MUL_CYCLES);
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_nxt = rem;
                     pend_lo_nxt = quo;
                     pend_dz_nxt = (B == 32'd0);
                     cnt_nxt     = CNT_W'(DIV_CYCLES);
                  end
                  OP_MTHI: hi_nxt = A;
                  OP_MTLO: lo_nxt = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Start is deliberately ignored here.
            cnt_nxt = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && !pend_dz_q) begin
               hi_nxt = pend_hi_q;
               lo_nxt = pend_lo_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         hi_q      <= hi_nxt;
         lo_q      <= lo_nxt;
         pend_hi_q <= pend_hi_nxt;
         pend_lo_q <= pend_lo_nxt;
         pend_dz_q <= pend_dz_nxt;
         cnt_q     <= cnt_nxt;
         // Busy mirrors (cnt != 0) but comes straight from a flop.
         busy_q    <= (cnt_nxt != '0);
      end
   end

   assign Busy = busy_q;
   assign Out  = Sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A, B;
   logic        Sel;
   logic [31:0] Out;
   logic        Busy;

   int checks   = 0;
   int failures = 0;

   logic [63:0] sb[$];   // expected {HI, LO} per mult/div issued

   localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                          OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

   mdu_iter #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .Sel(Sel), .Out(Out), .Busy(Busy)
   );

   always #5 clk = ~clk;

   // All tasks start and end just after a falling edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1; Op = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; Op = 3'd6;
      A = $urandom; B = $urandom;   // operands must be latched at issue
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      Sel = 1'b1; #1 h = Out;
      Sel = 1'b0; #1 l = Out;
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sbv, q, r;
      longint sp;
      longint unsigned ua, ub, up;
      sa = a; sbv = b; ua = a; ub = b;
      case (op)
         OP_MULT:  begin sp = longint'(sa) * longint'(sbv); return sp; end
         OP_MULTU: begin up = ua * ub; return up; end
         OP_DIV:   begin q = sa / sbv; r = sa % sbv; return {r, q}; end
         default:  return {a % b, a / b};
      endcase
   endfunction

   task automatic test_reset;
      logic [31:0] h, l;
      rst = 1'b1;
      // Start on a reset edge must lose to reset
      Start = 1'b1; Op = OP_MTHI; A = 32'hFFFF_0000;
      @(negedge clk);
      Start = 1'b0; Op = 3'd6;
      @(negedge clk);
      rst = 1'b0;
      read_hilo(h, l);
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++; if (h !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 0", h); end
      checks++; if (l !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 0", l); end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_cycles);
      int n;
      logic [63:0] e;
      logic [31:0] h, l;
      sb.push_back(exp);
      issue(op, a, b);
      wait_idle(n);
      checks++; if (n !== exp_cycles) begin failures++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, exp_cycles); end
      e = sb.pop_front();
      read_hilo(h, l);
      checks++; if (h !== e[63:32]) begin failures++; $display("FAIL %s_hi: got %h expected %h", name, h, e[63:32]); end
      checks++; if (l !== e[31:0]) begin failures++; $display("FAIL %s_lo: got %h expected %h", name, l, e[31:0]); end
   endtask

   task automatic test_mult;
      run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 5);
   endtask

   task automatic test_div;
      run_op("div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
      run_op("divu", OP_DIVU, 32'd7,         32'd2, {32'h0000_0001, 32'h0000_0003}, 10);
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      logic [2:0]  op;
      for (int i = 0; i < 8; i++) begin
         a  = $urandom;
         b  = (i < 4) ? $urandom : ($urandom >> $urandom_range(0, 31));
         op = 3'($urandom_range(0, 3));
         if (b == 32'd0) b = 32'd3;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
         run_op("rand", op, a, b, model(op, a, b), (op < 3'd2) ? 5 : 10);
      end
   endtask

   task automatic test_mtx;
      logic [31:0] h, l;
      Start = 1'b1; Op = OP_MTHI; A = 32'h1234;
      @(negedge clk);
      read_hilo(h, l);
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", Busy); end
      checks++; if (h !== 32'h1234) begin failures++; $display("FAIL mthi_hi: got %h expected 00001234", h); end
      Op = OP_MTLO; A = 32'h5678;
      @(negedge clk);
      Start = 1'b0; Op = 3'd6;
      read_hilo(h, l);
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy: got %b expected 0", Busy); end
      checks++; if (l !== 32'h5678) begin failures++; $display("FAIL mtlo_lo: got %h expected 00005678", l); end
      checks++; if (h !== 32'h1234) begin failures++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", h); end
   endtask

   task automatic test_div_zero;
      issue(OP_MTHI, 32'hAA, 32'd0);
      issue(OP_MTLO, 32'hBB, 32'd0);
      run_op("div0",  OP_DIV, 32'd5,         32'd0,         {32'hAA, 32'hBB}, 10);
      run_op("divov", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10);
   endtask

   task automatic test_back_to_back;
      int n;
      logic [63:0] e;
      logic [31:0] h, l;
      // mtlo during RUN must be ignored and must not disturb the count
      sb.push_back({32'h0, 32'd12});
      issue(OP_MULT, 32'd3, 32'd4);
      Start = 1'b1; Op = OP_MTLO; A = 32'hDEAD_BEEF;
      @(negedge clk);
      Start = 1'b0; Op = 3'd6;
      wait_idle(n);
      checks++; if (n !== 4) begin failures++; $display("FAIL ignore_busy_cycles: got %0d expected 4", n); end
      e = sb.pop_front();
      read_hilo(h, l);
      checks++; if (l !== e[31:0]) begin failures++; $display("FAIL ignore_lo: got %h expected %h", l, e[31:0]); end
      // issue in the first Busy=0 cycle
      sb.push_back({32'h0, 32'd30});
      issue(OP_MULTU, 32'd5, 32'd6);
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b expected 1", Busy); end
      wait_idle(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL b2b_busy_cycles: got %0d expected 5", n); end
      e = sb.pop_front();
      read_hilo(h, l);
      checks++; if (h !== e[63:32] || l !== e[31:0]) begin failures++; $display("FAIL b2b_result: got %h_%h expected %h", h, l, e); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] h, l;
      issue(OP_DIV, 32'd100, 32'd7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      read_hilo(h, l);
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", Busy); end
      checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL abort_hilo: got %h_%h expected 0_0", h, l); end
      repeat (12) @(negedge clk);
      read_hilo(h, l);
      checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL abort_no_commit: got %h_%h expected 0_0", h, l); end
   endtask

   initial begin
      rst = 1'b1; Start = 1'b0; Op = 3'd6; A = '0; B = '0; Sel = 1'b0;
      @(negedge clk);
      test_reset;
      test_mult;
      test_div;
      test_mtx;
      test_div_zero;
      test_back_to_back;
      test_random;
      test_reset_abort;
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
